// File: rtl/ab_game_pkg.sv
// Shared A/B game definitions: FSM/phase encodings, digit constants, display codes, code-layout helpers.
// Used by the solver, its probe builder, the judge and the display front end.
package ab_game_pkg;

    localparam int CODE_W = 16;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] PROBE_LAST = 4'd8;
    localparam logic [3:0] DISP_A     = 4'd10;
    localparam logic [3:0] DISP_B     = 4'd11;
    localparam logic [3:0] BLANK      = 4'd12;
    localparam logic [2:0] A_ALL      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef enum logic {
        PH_BASE  = 1'b0,
        PH_PROBE = 1'b1
    } phase_t;

    // Digit idx occupies [4*idx+3:4*idx]; digit 3 is the leftmost.
    function automatic logic [3:0] get_digit(input logic [CODE_W-1:0] code, input logic [1:0] idx);
        return code[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [CODE_W-1:0] set_digit(input logic [CODE_W-1:0] code,
                                                    input logic [1:0] idx,
                                                    input logic [3:0] val);
        logic [CODE_W-1:0] r;
        r = code;
        r[{idx, 2'b00} +: 4] = val;
        return r;
    endfunction

endpackage

// File: rtl/ab_auto_solver_if.sv
// Guess/result channel between the solver (master) and the game judge (slave).
// Guess uses valid/ready; the result is a one-cycle pulse with no backpressure.
interface ab_auto_solver_if;
    import ab_game_pkg::*;

    logic [CODE_W-1:0] guess;
    logic              guess_valid;
    logic              guess_ready;
    logic              result_valid;
    logic [2:0]        result_a;
    logic [2:0]        result_b;

    modport master (
        output guess, guess_valid,
        input  guess_ready, result_valid, result_a, result_b
    );

    modport slave (
        input  guess, guess_valid,
        output guess_ready, result_valid, result_a, result_b
    );
endinterface

// File: rtl/ab_probe_gen.sv
// Combinational guess builder: all zeros in BASE, otherwise zeros with digit pos set to the probe digit.
// Zero latency, no state.
module ab_probe_gen
    import ab_game_pkg::*;
(
    input  phase_t            i_phase,
    input  logic [1:0]        i_pos,
    input  logic [3:0]        i_digit,
    output logic [CODE_W-1:0] o_guess
);

    always_comb begin
        o_guess = '0;
        if (i_phase == PH_PROBE) begin
            o_guess = set_digit({CODE_W{1'b0}}, i_pos, i_digit);
        end
    end

endmodule

// File: rtl/ab_auto_solver.sv
// A/B code breaker: base guess 0000 gives the zero count, then probes one digit at a time (<=33 guesses).
// Guess waits indefinitely on guess_ready; result_valid is honoured only while waiting for a result.
module ab_auto_solver
    import ab_game_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int CNT_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    ab_auto_solver_if.master              judge,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    output logic [NUM_DIGITS*DIGIT_W-1:0] o_solution,
    output logic [CNT_W-1:0]              o_guess_cnt
);

    state_t                        r_state, w_next;
    phase_t                        r_phase;
    logic [1:0]                    r_p;
    logic [3:0]                    r_d;
    logic [2:0]                    r_a0, r_a;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_solution;
    logic [CNT_W-1:0]              r_cnt;
    logic [CODE_W-1:0]             w_guess;
    logic                          w_unused_b;

    logic [3:0] w_a4, w_a0_4, w_res_digit;
    logic       w_up, w_down, w_same, w_step, w_nine, w_resolved, w_last;
    logic       w_base_hit, w_bad_a;

    assign w_unused_b = ^judge.result_b;

    // Widened to 4 bits so a0+1 / a0-1 never wrap; a0-1 only counts when a0 is nonzero.
    assign w_a4        = {1'b0, r_a};
    assign w_a0_4      = {1'b0, r_a0};
    assign w_up        = (w_a4 == w_a0_4 + 4'd1);
    assign w_down      = (r_a0 != 3'd0) && (w_a4 == w_a0_4 - 4'd1);
    assign w_same      = (r_a == r_a0);
    assign w_step      = w_same && (r_d != PROBE_LAST);
    assign w_nine      = w_same && (r_d == PROBE_LAST);
    assign w_resolved  = w_up || w_down || w_nine;
    assign w_res_digit = w_up ? r_d : (w_down ? 4'd0 : DIGIT_MAX);
    assign w_last      = (r_p == 2'd3);
    assign w_base_hit  = (r_a == A_ALL);
    assign w_bad_a     = (r_a > A_ALL);

    ab_probe_gen u_probe_gen (
        .i_phase (r_phase),
        .i_pos   (r_p),
        .i_digit (r_d),
        .o_guess (w_guess)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_ISSUE;
            S_ISSUE: if (judge.guess_ready) w_next = S_WAIT;
            S_WAIT:  if (judge.result_valid) w_next = S_EVAL;
            S_EVAL: begin
                if (r_phase == PH_BASE)
                    w_next = w_base_hit ? S_DONE : (w_bad_a ? S_ERR : S_ISSUE);
                else if (w_resolved)
                    w_next = w_last ? S_DONE : S_ISSUE;
                else if (w_step)
                    w_next = S_ISSUE;
                else
                    w_next = S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        judge.guess       = w_guess;
        judge.guess_valid = (r_state == S_ISSUE);
        o_busy            = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_EVAL);
        o_done            = (r_state == S_DONE);
        o_error           = (r_state == S_ERR);
        o_solution        = r_solution;
        o_guess_cnt       = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_BASE;
            r_p        <= 2'd0;
            r_d        <= 4'd1;
            r_a0       <= 3'd0;
            r_a        <= 3'd0;
            r_solution <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (i_start) begin
                    r_phase    <= PH_BASE;
                    r_p        <= 2'd0;
                    r_d        <= 4'd1;
                    r_solution <= '0;
                    r_cnt      <= '0;
                end
                S_ISSUE: if (judge.guess_ready) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                S_WAIT:  if (judge.result_valid) r_a <= judge.result_a;
                S_EVAL: begin
                    if (r_phase == PH_BASE) begin
                        if (w_base_hit) begin
                            r_solution <= '0;
                        end else begin
                            r_a0    <= r_a;
                            r_p     <= 2'd0;
                            r_d     <= 4'd1;
                            r_phase <= PH_PROBE;
                        end
                    end else if (w_resolved) begin
                        r_solution <= set_digit(r_solution, r_p, w_res_digit);
                        if (!w_last) begin
                            r_p <= r_p + 2'd1;
                            r_d <= 4'd1;
                        end
                    end else if (w_step) begin
                        r_d <= r_d + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ab_auto_solver.sv
// Self-checking bench: a judge model scores guesses against a secret; expected guesses come from the strategy rules.
module tb_ab_auto_solver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_error;
    logic [15:0] o_solution;
    logic [5:0]  o_guess_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    ab_auto_solver_if bus ();

    ab_auto_solver #(.NUM_DIGITS(4), .DIGIT_W(4), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .judge       (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_solution  (o_solution),
        .o_guess_cnt (o_guess_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] calc_a(input logic [15:0] g, input logic [15:0] s);
        int c = 0;
        for (int i = 0; i < 4; i++) if (g[i*4 +: 4] == s[i*4 +: 4]) c++;
        return 3'(c);
    endfunction

    function automatic logic [15:0] probe(input int p, input int d);
        logic [15:0] v;
        v = '0;
        v[p*4 +: 4] = 4'(d);
        return v;
    endfunction

    function automatic logic [15:0] rand_secret();
        logic [15:0] s;
        for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
        return s;
    endfunction

    // bad_idx >= 0: the judge answers guess #bad_idx with bad_a and the solve must end in error.
    task automatic run_solve(input logic [15:0] secret, input int stall_idx,
                             input int bad_idx, input logic [2:0] bad_a);
        logic [15:0] exp_q[$];
        logic [15:0] g;
        logic [2:0]  a;
        int          n, cyc, sd;
        bit          fin;

        exp_q.push_back(16'h0000);
        if (secret != 16'h0000) begin
            for (int p = 0; p < 4; p++) begin
                sd = int'(secret[p*4 +: 4]);
                if (sd == 0) exp_q.push_back(probe(p, 1));
                else for (int d = 1; d <= ((sd > 8) ? 8 : sd); d++) exp_q.push_back(probe(p, d));
            end
        end

        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        chk("start_cnt", 32'(o_guess_cnt), 0);
        chk("start_sol", 32'(o_solution), 0);

        n = 0; cyc = 0; fin = 0;
        while (!fin) begin
            if (o_done || o_error) begin
                fin = 1;
            end else if (cyc > 2000) begin
                chk("timeout", 32'(cyc), 0);
                fin = 1;
            end else if (bus.guess_valid) begin
                g = bus.guess;
                if (n == stall_idx) begin
                    for (int k = 0; k < 5; k++) begin
                        i_start = (k == 2);
                        @(negedge clk); cyc++;
                        chk("stall_vld", 32'(bus.guess_valid), 1);
                        chk("stall_guess", 32'(bus.guess), 32'(g));
                        chk("stall_cnt", 32'(o_guess_cnt), 32'(n));
                    end
                    i_start = 1'b0;
                end
                if (n < exp_q.size()) chk("guess_seq", 32'(g), 32'(exp_q[n]));
                else                  chk("extra_guess", 32'(n), 32'(exp_q.size()));
                bus.guess_ready = 1'b1;
                @(negedge clk); cyc++;
                bus.guess_ready = 1'b0;
                n++;
                chk("xfer_cnt", 32'(o_guess_cnt), 32'(n));
                chk("vld_drop", 32'(bus.guess_valid), 0);
                a = (n - 1 == bad_idx) ? bad_a : calc_a(g, secret);
                repeat ($urandom_range(0, 3)) begin @(negedge clk); cyc++; end
                bus.result_valid = 1'b1;
                bus.result_a     = a;
                bus.result_b     = 3'($urandom_range(0, 4));
                @(negedge clk); cyc++;
                bus.result_valid = 1'b0;
            end else begin
                @(negedge clk); cyc++;
            end
        end

        chk("end_busy", 32'(o_busy), 0);
        if (bad_idx < 0) begin
            chk("end_done", 32'(o_done), 1);
            chk("end_err", 32'(o_error), 0);
            chk("end_sol", 32'(o_solution), 32'(secret));
            chk("end_cnt", 32'(o_guess_cnt), 32'(exp_q.size()));
        end else begin
            chk("err_flag", 32'(o_error), 1);
            chk("err_done", 32'(o_done), 0);
            chk("err_cnt", 32'(o_guess_cnt), 32'(bad_idx + 1));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_guess"}, 32'(bus.guess), 0);
        chk({tag, "_vld"},   32'(bus.guess_valid), 0);
        chk({tag, "_busy"},  32'(o_busy), 0);
        chk({tag, "_done"},  32'(o_done), 0);
        chk({tag, "_err"},   32'(o_error), 0);
        chk({tag, "_sol"},   32'(o_solution), 0);
        chk({tag, "_cnt"},   32'(o_guess_cnt), 0);
    endtask

    initial begin
        bus.guess_ready  = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_a     = 3'd0;
        bus.result_b     = 3'd0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        run_solve(16'h0000, -1, -1, 3'd0);
        run_solve(16'h1234, -1, -1, 3'd0);
        run_solve(16'h9999, -1, -1, 3'd0);
        run_solve(16'h0900, -1, -1, 3'd0);
        run_solve(rand_secret(), 2, -1, 3'd0);

        // a0 is 0 for a secret without zeros, so A=2 on the first probe is inconsistent.
        run_solve(16'h1111, -1, 1, 3'd2);
        run_solve(rand_secret(), -1, -1, 3'd0);

        // Reset while waiting for a result, then a stray result pulse.
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        chk("mid_vld", 32'(bus.guess_valid), 1);
        bus.guess_ready = 1'b1;
        @(negedge clk); bus.guess_ready = 1'b0;
        chk("mid_busy", 32'(o_busy), 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_reset_vals("mid_rst");
        bus.result_valid = 1'b1;
        bus.result_a     = 3'd1;
        @(negedge clk); bus.result_valid = 1'b0;
        @(negedge clk);
        chk("late_busy", 32'(o_busy), 0);
        chk("late_vld", 32'(bus.guess_valid), 0);
        chk("late_cnt", 32'(o_guess_cnt), 0);
        run_solve(16'h5067, -1, -1, 3'd0);

        for (int t = 0; t < 20; t++) run_solve(rand_secret(), -1, -1, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
